parser: RTL

PARSER -- requirements
Module: parser

---
 rtl/parser_pkg.sv | 54 +++++
 rtl/parser_token_fifo.sv | 55 +++++
 rtl/parser.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/parser_pkg.sv
// Shared token/instruction definitions for the lexer and parser.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package parser_pkg;

  // Token tags produced by the lexer.
  localparam logic [7:0] TAG_NUM     = 8'h00;
  localparam logic [7:0] TAG_PLUS    = 8'h01;
  localparam logic [7:0] TAG_MINUS   = 8'h02;
  localparam logic [7:0] TAG_EQUAL   = 8'h03;
  localparam logic [7:0] TAG_SEMI    = 8'h04;
  localparam logic [7:0] TAG_VARNAME = 8'h05;
  localparam logic [7:0] TAG_CHAR    = 8'h80;
  localparam logic [7:0] TAG_RETURN  = 8'h81;

  // Stack-machine opcodes emitted by the parser.
  localparam logic [7:0] OP_PUSHI = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_STORE = 8'h05;
  localparam logic [7:0] OP_ALLOC = 8'h06;
  localparam logic [7:0] OP_RET   = 8'h07;
  localparam logic [7:0] OP_ERR   = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECL_VAR,
    ST_DECL_SEMI,
    ST_ASG_EQ,
    ST_TERM,
    ST_OP,
    ST_EMIT_OP,
    ST_SYNC
  } state_e;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] value;
  } token_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] operand;
  } instr_t;

  function automatic instr_t mk_instr(input logic [7:0] opcode, input logic [7:0] operand);
    instr_t r;
    r.opcode  = opcode;
    r.operand = operand;
    return r;
  endfunction

endpackage

// File: rtl/parser_token_fifo.sv
// Token FIFO between lexer and parser FSM; DEPTH entries, sticky overflow flag.
// Latency: a pushed token is visible on pop_data from the next cycle.
// Backpressure: none upstream; a push while full without a same-cycle pop is dropped.
// Ports: clk/rst_n, push/push_data (write), pop/pop_data (read head),
//        full/empty status, overflow (sticky drop indicator).
module token_fifo
  import parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  token_t push_data,
  input  logic   pop,
  output token_t pop_data,
  output logic   full,
  output logic   empty,
  output logic   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  token_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // At full, a same-cycle pop frees the slot the write lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/parser.sv
// Token-stream parser: turns lexer tokens into stack-machine instructions.
// Latency: instruction appears on O_VALID/O_DATA the cycle after the token pop.
// Backpressure: O_READY stalls token pops; tokens buffer in the FIFO, excess dropped (O_OVF).
// Ports: CLK/RST, I_VALID/I_DATA token input, O_VALID/O_READY/O_DATA instruction
//        output, O_OVF sticky FIFO overflow, O_ERR sticky syntax error.
module parser
  import parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [15:0] O_DATA,
  output logic        O_OVF,
  output logic        O_ERR
);

  token_t     tok;
  logic       fifo_empty;
  logic       fifo_full_unused;   // the FSM only needs empty; full is handled inside the FIFO
  logic       pop;
  logic       slot_free;
  logic       tok_ok;
  state_e     state;
  logic       pend_vld;           // an ADD/SUB is waiting for its right-hand term
  logic       pend_sub;
  logic       tgt_ret;            // statement ends in RET rather than STORE
  logic [7:0] tgt_var;            // STORE target, or ALLOC variable

  token_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (I_VALID),
    .push_data (I_DATA),
    .pop       (pop),
    .pop_data  (tok),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .overflow  (O_OVF)
  );

  assign slot_free = !O_VALID || O_READY;
  // EMIT_OP produces an instruction without consuming a token, so it blocks pops.
  assign pop = !fifo_empty && (state != ST_EMIT_OP) && slot_free;

  // Is the head token legal in the current state?
  always_comb begin
    tok_ok = 1'b0;
    case (state)
      ST_IDLE:      tok_ok = tok.tag inside {TAG_CHAR, TAG_VARNAME, TAG_RETURN, TAG_SEMI};
      ST_DECL_VAR:  tok_ok = (tok.tag == TAG_VARNAME);
      ST_DECL_SEMI: tok_ok = (tok.tag == TAG_SEMI);
      ST_ASG_EQ:    tok_ok = (tok.tag == TAG_EQUAL);
      ST_TERM:      tok_ok = (tok.tag == TAG_NUM) || (tok.tag == TAG_VARNAME);
      ST_OP:        tok_ok = tok.tag inside {TAG_PLUS, TAG_MINUS, TAG_SEMI};
      default:      tok_ok = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      O_VALID  <= 1'b0;
      O_DATA   <= 16'h0000;
      O_ERR    <= 1'b0;
      pend_vld <= 1'b0;
      pend_sub <= 1'b0;
      tgt_ret  <= 1'b0;
      tgt_var  <= 8'h00;
    end else begin
      // Consumer took the current instruction; a new emission below overrides this.
      if (O_READY) O_VALID <= 1'b0;

      if (state == ST_EMIT_OP) begin
        if (slot_free) begin
          O_VALID  <= 1'b1;
          O_DATA   <= mk_instr(pend_sub ? OP_SUB : OP_ADD, 8'h00);
          pend_vld <= 1'b0;
          state    <= ST_OP;
        end
      end else if (pop) begin
        if (state == ST_SYNC) begin
          if (tok.tag == TAG_SEMI) state <= ST_IDLE;
        end else if (!tok_ok) begin
          O_VALID  <= 1'b1;
          O_DATA   <= mk_instr(OP_ERR, tok.tag);
          O_ERR    <= 1'b1;
          pend_vld <= 1'b0;
          state    <= ST_SYNC;
        end else begin
          case (state)
            ST_IDLE: begin
              case (tok.tag)
                TAG_CHAR:    state <= ST_DECL_VAR;
                TAG_VARNAME: begin
                  tgt_ret <= 1'b0;
                  tgt_var <= tok.value;
                  state   <= ST_ASG_EQ;
                end
                TAG_RETURN:  begin
                  tgt_ret <= 1'b1;
                  state   <= ST_TERM;
                end
                default: ;  // empty statement
              endcase
            end
            ST_DECL_VAR: begin
              tgt_var <= tok.value;
              state   <= ST_DECL_SEMI;
            end
            ST_DECL_SEMI: begin
              O_VALID <= 1'b1;
              O_DATA  <= mk_instr(OP_ALLOC, tgt_var);
              state   <= ST_IDLE;
            end
            ST_ASG_EQ: state <= ST_TERM;
            ST_TERM: begin
              O_VALID <= 1'b1;
              O_DATA  <= mk_instr((tok.tag == TAG_NUM) ? OP_PUSHI : OP_LOAD, tok.value);
              // Postfix order: the operator follows its right-hand term.
              state   <= pend_vld ? ST_EMIT_OP : ST_OP;
            end
            ST_OP: begin
              if (tok.tag == TAG_SEMI) begin
                O_VALID <= 1'b1;
                O_DATA  <= tgt_ret ? mk_instr(OP_RET, 8'h00) : mk_instr(OP_STORE, tgt_var);
                state   <= ST_IDLE;
              end else begin
                pend_vld <= 1'b1;
                pend_sub <= (tok.tag == TAG_MINUS);
                state    <= ST_TERM;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
